// File: rtl/elastic_register_chain_if.sv
// Valid/ready word stream used on both sides of the elastic register chain.
// The master drives valid and data; the slave drives ready.
interface elastic_register_chain_if #(
  parameter int unsigned WORD_WIDTH = 8
) ();
  logic                  valid;
  logic                  ready;
  logic [WORD_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_register_chain.sv
// Chain of DEPTH two-entry skid-buffer stages on a valid/ready stream. Every ready is
// decoded from registered stage state, so no combinational ready path crosses the chain.
module elastic_register_chain #(
  parameter int unsigned           WORD_WIDTH  = 8,
  parameter int unsigned           DEPTH       = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned          OccWidth    = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      clear,
  elastic_register_chain_if.slave   s_if,
  elastic_register_chain_if.master  m_if,
  output logic [OccWidth-1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  if (DEPTH == 0) begin : g_bypass
    assign s_if.ready = m_if.ready;
    assign m_if.valid = s_if.valid;
    assign m_if.data  = s_if.data;
    assign occupancy  = '0;

    logic unused_ctrl;
    assign unused_ctrl = ^{clock, resetn, clear};
  end else begin : g_chain
    // Link k is the input of stage k; link DEPTH is the chain output.
    logic                  link_valid [DEPTH+1];
    logic                  link_ready [DEPTH+1];
    logic [WORD_WIDTH-1:0] link_data  [DEPTH+1];
    logic [1:0]            stage_occ  [DEPTH];
    logic [OccWidth-1:0]   occ_sum;

    assign link_valid[0]     = s_if.valid;
    assign link_data[0]      = s_if.data;
    assign s_if.ready        = link_ready[0];
    assign m_if.valid        = link_valid[DEPTH];
    assign m_if.data         = link_data[DEPTH];
    assign link_ready[DEPTH] = m_if.ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      stage_state_e          state_q, state_d;
      logic [WORD_WIDTH-1:0] main_q, main_d;
      logic [WORD_WIDTH-1:0] skid_q, skid_d;
      logic                  in_xfer, out_xfer;

      assign link_ready[k]   = (state_q != StFull);
      assign link_valid[k+1] = (state_q != StEmpty);
      assign link_data[k+1]  = main_q;

      assign in_xfer  = link_valid[k] && link_ready[k];
      assign out_xfer = link_valid[k+1] && link_ready[k+1];

      assign stage_occ[k] = (state_q == StFull) ? 2'd2 :
                            (state_q == StBusy) ? 2'd1 : 2'd0;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Clear wins over any handshake in the same cycle; the offered word is dropped.
        if (clear) begin
          state_d = StEmpty;
          main_d  = RESET_VALUE;
          skid_d  = RESET_VALUE;
        end else begin
          unique case (state_q)
            StEmpty: begin
              if (in_xfer) begin
                state_d = StBusy;
                main_d  = link_data[k];
              end
            end
            StBusy: begin
              if (in_xfer && out_xfer) begin
                main_d = link_data[k];
              end else if (in_xfer) begin
                state_d = StFull;
                skid_d  = link_data[k];
              end else if (out_xfer) begin
                state_d = StEmpty;
              end
            end
            StFull: begin
              if (out_xfer) begin
                state_d = StBusy;
                main_d  = skid_q;
              end
            end
            default: state_d = StEmpty;
          endcase
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          state_q <= StEmpty;
          main_q  <= RESET_VALUE;
          skid_q  <= RESET_VALUE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end

    always_comb begin
      occ_sum = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        occ_sum = occ_sum + OccWidth'(stage_occ[k]);
      end
    end

    assign occupancy = occ_sum;
  end

endmodule

// File: tb/tb_elastic_register_chain.sv
// Bench for elastic_register_chain: cycle table on DEPTH=2, async reset, randomized
// scoreboard on DEPTH=1/2/5, and combinational checks on DEPTH=0.
module tb_elastic_register_chain;

  localparam int unsigned NumDut = 3;
  localparam int unsigned DepthTab [NumDut] = '{1, 2, 5};
  localparam logic [7:0]  RstVal = 8'h5A;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clock;
  logic resetn;

  logic       sv  [NumDut];
  logic [7:0] sd  [NumDut];
  logic       mr  [NumDut];
  logic       clr [NumDut];
  logic       sr  [NumDut];
  logic       mv  [NumDut];
  logic [7:0] md  [NumDut];
  logic [7:0] occ [NumDut];

  int checks;
  int errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned D  = DepthTab[g];
    localparam int unsigned OW = $clog2(2 * D + 1);
    logic [OW-1:0] occ_w;
    elastic_register_chain_if #(.WORD_WIDTH(8)) s_if ();
    elastic_register_chain_if #(.WORD_WIDTH(8)) m_if ();
    assign s_if.valid = sv[g];
    assign s_if.data  = sd[g];
    assign sr[g]      = s_if.ready;
    assign m_if.ready = mr[g];
    assign mv[g]      = m_if.valid;
    assign md[g]      = m_if.data;
    assign occ[g]     = 8'(occ_w);
    elastic_register_chain #(.WORD_WIDTH(8), .DEPTH(D), .RESET_VALUE(RstVal)) u_dut (
      .clock     (clock),
      .resetn    (resetn),
      .clear     (clr[g]),
      .s_if      (s_if),
      .m_if      (m_if),
      .occupancy (occ_w)
    );
  end

  // DEPTH=0 pass-through instance
  logic       z_sv, z_mr, z_clr;
  logic [7:0] z_sd;
  logic       z_occ;
  elastic_register_chain_if #(.WORD_WIDTH(8)) z_s_if ();
  elastic_register_chain_if #(.WORD_WIDTH(8)) z_m_if ();
  assign z_s_if.valid = z_sv;
  assign z_s_if.data  = z_sd;
  assign z_m_if.ready = z_mr;
  elastic_register_chain #(.WORD_WIDTH(8), .DEPTH(0), .RESET_VALUE(RstVal)) u_dut0 (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (z_clr),
    .s_if      (z_s_if),
    .m_if      (z_m_if),
    .occupancy (z_occ)
  );

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       clr;
    logic       e_sr;
    logic       e_mv;
    logic       chk_md;
    logic [7:0] e_md;
    logic [7:0] e_occ;
  } vec_t;

  localparam int NumVec = 23;
  vec_t tab [NumVec];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r, input logic c,
                              input logic esr, input logic emv, input logic cmd,
                              input logic [7:0] emd, input logic [7:0] eocc);
    vec_t x;
    x.sv = v; x.sd = d; x.mr = r; x.clr = c;
    x.e_sr = esr; x.e_mv = emv; x.chk_md = cmd; x.e_md = emd; x.e_occ = eocc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] sb [NumDut][$];
  logic       s_acc [NumDut];
  logic [7:0] exp_w;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    z_sv = 1'b0; z_sd = 8'h00; z_mr = 1'b0; z_clr = 1'b0;
    for (int g = 0; g < NumDut; g++) begin
      sv[g] = 1'b0; sd[g] = 8'h00; mr[g] = 1'b0; clr[g] = 1'b0; s_acc[g] = 1'b0;
    end

    // Fill/stall/drain, then clear with a word offered, on DEPTH=2 (index 1)
    tab[0]  = mk(T, 8'hA0, F, F, T, F, T, RstVal, 8'd0);
    tab[1]  = mk(T, 8'hA1, F, F, T, F, T, RstVal, 8'd1);
    tab[2]  = mk(T, 8'hA2, F, F, T, T, T, 8'hA0,  8'd2);
    tab[3]  = mk(T, 8'hA3, F, F, T, T, T, 8'hA0,  8'd3);
    tab[4]  = mk(T, 8'hA4, F, F, F, T, T, 8'hA0,  8'd4);
    tab[5]  = mk(T, 8'hA4, F, F, F, T, T, 8'hA0,  8'd4);
    tab[6]  = mk(T, 8'hA4, T, F, F, T, T, 8'hA0,  8'd4);
    tab[7]  = mk(T, 8'hA4, T, F, F, T, T, 8'hA1,  8'd3);
    tab[8]  = mk(T, 8'hA4, T, F, T, T, T, 8'hA2,  8'd2);
    tab[9]  = mk(T, 8'hA5, T, F, T, T, T, 8'hA3,  8'd2);
    tab[10] = mk(T, 8'hA6, T, F, T, T, T, 8'hA4,  8'd2);
    tab[11] = mk(T, 8'hA7, T, F, T, T, T, 8'hA5,  8'd2);
    tab[12] = mk(F, 8'h00, T, F, T, T, T, 8'hA6,  8'd2);
    tab[13] = mk(F, 8'h00, T, F, T, T, T, 8'hA7,  8'd1);
    tab[14] = mk(F, 8'h00, F, F, T, F, F, 8'h00,  8'd0);
    tab[15] = mk(T, 8'hB0, F, F, T, F, F, 8'h00,  8'd0);
    tab[16] = mk(T, 8'hB1, F, F, T, F, F, 8'h00,  8'd1);
    tab[17] = mk(T, 8'hB2, F, F, T, T, T, 8'hB0,  8'd2);
    tab[18] = mk(T, 8'h55, T, T, T, T, T, 8'hB0,  8'd3);
    tab[19] = mk(T, 8'hC0, T, F, T, F, T, RstVal, 8'd0);
    tab[20] = mk(F, 8'h00, T, F, T, F, T, RstVal, 8'd1);
    tab[21] = mk(F, 8'h00, T, F, T, T, T, 8'hC0,  8'd1);
    tab[22] = mk(F, 8'h00, T, F, T, F, F, 8'h00,  8'd0);

    #12 resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < NumVec; i++) begin
      sv[1] = tab[i].sv; sd[1] = tab[i].sd; mr[1] = tab[i].mr; clr[1] = tab[i].clr;
      #1;
      chk($sformatf("row%0d s_ready", i), 32'(sr[1]), 32'(tab[i].e_sr));
      chk($sformatf("row%0d m_valid", i), 32'(mv[1]), 32'(tab[i].e_mv));
      chk($sformatf("row%0d occupancy", i), 32'(occ[1]), 32'(tab[i].e_occ));
      if (tab[i].chk_md) chk($sformatf("row%0d m_data", i), 32'(md[1]), 32'(tab[i].e_md));
      @(posedge clock); #1;
    end
    sv[1] = 1'b0; mr[1] = 1'b0; clr[1] = 1'b0;

    // Asynchronous reset between edges while words are held
    @(posedge clock); #1;
    for (int g = 0; g < NumDut; g++) begin
      sv[g] = 1'b1; sd[g] = 8'h33; mr[g] = 1'b0;
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("prefill occ depth1", 32'(occ[0]), 32'd2);
    chk("prefill occ depth2", 32'(occ[1]), 32'd3);
    chk("prefill occ depth5", 32'(occ[2]), 32'd3);
    #2;
    resetn = 1'b0;
    for (int g = 0; g < NumDut; g++) sv[g] = 1'b0;
    #1;
    for (int g = 0; g < NumDut; g++) begin
      chk($sformatf("async rst m_valid d%0d", g), 32'(mv[g]), 32'd0);
      chk($sformatf("async rst m_data d%0d", g), 32'(md[g]), 32'(RstVal));
      chk($sformatf("async rst s_ready d%0d", g), 32'(sr[g]), 32'd1);
      chk($sformatf("async rst occ d%0d", g), 32'(occ[g]), 32'd0);
    end
    #2 resetn = 1'b1;
    @(posedge clock); #1;

    // Randomized traffic against an ordered-queue scoreboard, then drain
    for (int cyc = 0; cyc < 2060; cyc++) begin
      for (int g = 0; g < NumDut; g++) begin
        chk("rnd occupancy", 32'(occ[g]), 32'(sb[g].size()));
        chk("rnd m_valid while empty", 32'(mv[g] && (sb[g].size() == 0)), 32'd0);
        chk("rnd s_ready low below 2", 32'(sr[g] || (sb[g].size() >= 2)), 32'd1);
        if (!sv[g] || s_acc[g]) begin
          sv[g] = (cyc < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
          sd[g] = 8'($urandom);
        end
        mr[g] = (cyc < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      for (int g = 0; g < NumDut; g++) begin
        s_acc[g] = sv[g] && sr[g];
        if (mv[g] && mr[g]) begin
          if (sb[g].size() == 0) begin
            chk("rnd unexpected word", 32'(md[g]), 32'hFFFF_FFFF);
          end else begin
            exp_w = sb[g].pop_front();
            chk("rnd data order", 32'(md[g]), 32'(exp_w));
          end
        end
        if (s_acc[g]) sb[g].push_back(sd[g]);
      end
      @(posedge clock); #1;
    end
    for (int g = 0; g < NumDut; g++) begin
      chk($sformatf("drain words left d%0d", g), 32'(sb[g].size()), 32'd0);
      chk($sformatf("drain occ d%0d", g), 32'(occ[g]), 32'd0);
    end

    // DEPTH=0 pass-through
    for (int i = 0; i < 12; i++) begin
      z_sv  = 1'($urandom_range(0, 1));
      z_sd  = 8'($urandom);
      z_mr  = 1'($urandom_range(0, 1));
      z_clr = 1'($urandom_range(0, 1));
      #3;
      chk("d0 m_valid", 32'(z_m_if.valid), 32'(z_sv));
      chk("d0 m_data", 32'(z_m_if.data), 32'(z_sd));
      chk("d0 s_ready", 32'(z_s_if.ready), 32'(z_mr));
      chk("d0 occupancy", 32'(z_occ), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
